div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle sequencer for the HI/LO-producing divide path of the EX stage. It accepts a DIV/DIVU request from EX, runs a 32-iteration shift-subtract loop over an internal working register, applies MIPS sign correction, and returns a 64-bit {remainder, quotient} pair that EX writes to HI/LO. It stalls the pipeline while busy and honours an annul from the pipeline controller (flush/exception).

## Interface
- DATA_W, 32: operand width; only 32 is supported.
- CNT_W, 6: iteration counter width; must hold the value DATA_W.
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset. One clock; reset is asynchronous and active-low.
- signed_div_i, in, 1: 1 selects DIV (signed); 0 selects DIVU.
- opdata1_i, in, 32: dividend; sampled only on acceptance.
- opdata2_i, in, 32: divisor; sampled only on acceptance.
- start_i, in, 1: request. Must be held high until ready_o is seen.
- annul_i, in, 1: cancel the current operation.
- result_o, out, 64: {remainder[63:32], quotient[31:0]}; registered.
- ready_o, out, 1: result valid; registered.
- stallreq_o, out, 1: combinational, equal to start_i & ~ready_o.

## Operation
- States: IDLE, DIVZERO, RUN, DONE.
- Reset (asynchronous, any state):
  - state goes to IDLE;
  - result_o, ready_o, the counter and the working register all clear to 0;
  - stallreq_o still follows start_i combinationally.
- IDLE:
  - If start_i=1, annul_i=0 and opdata2_i=0: go to DIVZERO.
  - If start_i=1, annul_i=0 and opdata2_i≠0: go to RUN and set cnt=0.
  - On entry to RUN, latch abs(op1) and abs(op2) when signed_div_i=1 and the operand MSB is set; otherwise latch the raw values.
  - On entry to RUN, also latch op1[31], op2[31] and signed_div_i for the sign fix.
  - The 65-bit working register W loads {32'b0, abs(op1), 1'b0}.
  - If start_i=1 and annul_i=1 in the same cycle: stay in IDLE.
- RUN, while cnt<32 and annul_i=0, each cycle:
  - Compute t = {1'b0, W[63:32]} − {1'b0, divisor}.
  - If t[32]=1: W ← {W[63:0], 1'b0}.
  - If t[32]=0: W ← {t[31:0], W[31:0], 1'b1}.
  - cnt ← cnt+1.
- RUN, with cnt=32 and annul_i=0:
  - q = W[31:0], r = W[64:33].
  - If signed and op1[31]^op2[31]: q ← −q (two's complement).
  - If signed and op1[31]: r ← −r.
  - result_o ← {r, q}; ready_o ← 1; go to DONE.
- DIVZERO, with annul_i=0: result_o ← 0, ready_o ← 1, go to DONE.
- annul_i=1, or start_i=0, in DIVZERO or RUN: go to IDLE next edge. ready_o stays 0 and W is discarded.
- DONE:
  - Hold result_o and ready_o while start_i=1 and annul_i=0.
  - When start_i=0 or annul_i=1: go to IDLE with ready_o ← 0 and result_o ← 0.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: result is deterministic, q=0x80000000 and r=0. No exception is raised.
- Operands presented after acceptance are ignored.

## Timing
- Cycle 0 is the first cycle in IDLE with start_i=1.
- Normal divide: RUN occupies cycles 1–33 (32 iterations plus the fix-up cycle). ready_o=1 and result_o are valid in cycle 34, i.e. 34 cycles of stallreq_o.
- Divide by zero: DIVZERO in cycle 1; ready_o=1 in cycle 2.
- stallreq_o has zero latency and drops in the same cycle ready_o rises.
- Back-to-back requests: EX must drop start_i for at least one cycle after ready_o, so DONE→IDLE takes one cycle. A new request is accepted no earlier than the next IDLE cycle.

## Test plan
- DIVU 100 / 7 -> ready_o rises in cycle 34; result_o = {0x00000002, 0x0000000E}; stallreq_o is high in cycles 0–33.
- DIV −7 (0xFFFFFFF9) / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2 -> {0x00000001, 0xFFFFFFFD}.
- DIVU 5 / 0 -> DIVZERO in cycle 1; ready_o in cycle 2; result_o = 0.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = {0x00000000, 0x80000000} in cycle 34. DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- annul_i pulsed in cycle 10 of a divide -> IDLE in cycle 11; ready_o never rises. An immediate new DIVU 9/3 then returns {0, 3} 34 cycles after its start.
- rst asserted low asynchronously mid-RUN (cycle 20) -> ready_o and result_o go to 0 immediately; FSM is in IDLE after release. start_i dropped in cycle 15 -> IDLE in cycle 16 with no ready_o.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed/unsigned 32-bit divider producing {remainder, quotient} for HI/LO.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   signed_div_i - 1 = DIV (signed), 0 = DIVU
//   opdata1_i    - dividend, sampled on acceptance
//   opdata2_i    - divisor, sampled on acceptance
//   start_i      - request, held until ready_o
//   annul_i      - cancel current operation
//   result_o     - registered {remainder, quotient}
//   ready_o      - registered result valid
//   stallreq_o   - start_i & ~ready_o, combinational
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);
    typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   w;
    logic [DATA_W-1:0]   divisor;
    logic                s1, s2, sgn;
    logic [DATA_W-1:0]   abs1, abs2, q_fix, r_fix;
    logic [DATA_W:0]     t;
    assign stallreq_o = start_i & ~ready_o;
    assign abs1  = (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2  = (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // trial subtraction of the divisor from the current partial remainder
    assign t     = {1'b0, w[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    // quotient sign follows operand signs, remainder sign follows the dividend
    assign q_fix = (sgn & (s1 ^ s2)) ? -w[DATA_W-1:0] : w[DATA_W-1:0];
    assign r_fix = (sgn & s1) ? -w[2*DATA_W:DATA_W+1] : w[2*DATA_W:DATA_W+1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            w        <= '0;
            divisor  <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            sgn      <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state <= DIVZERO;
                    end else begin
                        state   <= RUN;
                        cnt     <= '0;
                        divisor <= abs2;
                        w       <= {{DATA_W{1'b0}}, abs1, 1'b0};
                        s1      <= opdata1_i[DATA_W-1];
                        s2      <= opdata2_i[DATA_W-1];
                        sgn     <= signed_div_i;
                    end
                end
                DIVZERO: if (annul_i || !start_i) begin
                    state <= IDLE;
                end else begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= DONE;
                end
                RUN: if (annul_i || !start_i) begin
                    state <= IDLE;
                end else if (cnt != CNT_W'(DATA_W)) begin
                    w   <= t[DATA_W] ? {w[2*DATA_W-1:0], 1'b0}
                                     : {t[DATA_W-1:0], w[DATA_W-1:0], 1'b1};
                    cnt <= cnt + 1'b1;
                end else begin
                    result_o <= {r_fix, q_fix};
                    ready_o  <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (!start_i || annul_i) begin
                    state    <= IDLE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;
    int          total = 0;
    int          bad = 0;

    div_seq dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div),
        .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready), .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request in the current (IDLE) cycle, check stall/ready every cycle
    // up to the expected latency, the result, the DONE hold, and the return to IDLE.
    task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        signed_div = sg; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        #1;
        for (int c = 0; c < lat; c++) begin
            chk({tag, "_stall"}, 64'(stallreq), 64'd1);
            chk({tag, "_busy"}, 64'(ready), 64'd0);
            step();
            op1 = ~a; op2 = b ^ 32'h5a5a_0001; signed_div = ~sg;
            #1;
        end
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_stall_drop"}, 64'(stallreq), 64'd0);
        chk({tag, "_result"}, result, exp);
        step();
        chk({tag, "_hold_ready"}, 64'(ready), 64'd1);
        chk({tag, "_hold_result"}, result, exp);
        start = 1'b0;
        step();
        chk({tag, "_idle_ready"}, 64'(ready), 64'd0);
        chk({tag, "_idle_result"}, result, 64'd0);
    endtask

    initial begin
        #1;
        chk("rst_result", result, 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_stall_lo", 64'(stallreq), 64'd0);
        start = 1'b1;
        #1;
        chk("rst_stall_hi", 64'(stallreq), 64'd1);
        start = 1'b0;
        step();
        rst = 1'b1;
        step();

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34);
        do_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, {32'h7FFF_FFFF, 32'h1}, 34);

        // annul in cycle 10, then an immediate new request
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("annul_busy", 64'(ready), 64'd0);
        end
        annul = 1'b1;
        step();
        annul = 1'b0;
        #1;
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_stall", 64'(stallreq), 64'd1);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34);

        // start dropped in cycle 15; no result may ever appear
        signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
        for (int c = 0; c < 15; c++) step();
        start = 1'b0;
        #1;
        chk("drop_stall", 64'(stallreq), 64'd0);
        for (int c = 0; c < 40; c++) begin
            step();
            chk("drop_ready", 64'(ready), 64'd0);
        end
        do_div("divu_50_5", 1'b0, 32'd50, 32'd5, {32'h0, 32'hA}, 34);

        // asynchronous reset mid-RUN at cycle 20
        signed_div = 1'b1; op1 = 32'hFFFF_FF9C; op2 = 32'd7; start = 1'b1;
        for (int c = 0; c < 20; c++) step();
        rst = 1'b0;
        #1;
        chk("arst_run_ready", 64'(ready), 64'd0);
        chk("arst_run_result", result, 64'd0);
        chk("arst_run_stall", 64'(stallreq), 64'd1);
        step();
        start = 1'b0;
        rst = 1'b1;
        step();
        chk("arst_after_ready", 64'(ready), 64'd0);
        do_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34);

        // asynchronous reset while holding a result in DONE
        signed_div = 1'b0; op1 = 32'd8; op2 = 32'd2; start = 1'b1;
        for (int c = 0; c < 34; c++) step();
        chk("done_ready", 64'(ready), 64'd1);
        chk("done_result", result, {32'h0, 32'h4});
        #2;
        rst = 1'b0;
        #1;
        chk("arst_done_ready", 64'(ready), 64'd0);
        chk("arst_done_result", result, 64'd0);
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        do_div("divu_8_2", 1'b0, 32'd8, 32'd2, {32'h0, 32'h4}, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
